srt4_host_seq: RTL and testbench
================================

// Module: srt4_host_seq
// PURPOSE
//  Host-side initiator for the srt4 divider: accepts a parallel (dividend, divisor) request,
//  sequences beginSignal/inbus into the divider, waits for endSignal, captures quotient and
//  remainder from outbus and returns them on a valid/ready response port.
//  Sits between system logic and srt4; it drives the divider's input side and reads its output side.
// PARAMETERS
//  W              8    operand/result width; equals inbus/outbus width
//  DVD_CYCLES     2    cycles dividend held on inbus (begin cycle included) before divisor
//  TIMEOUT_CYCLES 64   max cycles in WAIT before abort (used only with SRT4_HOST_TIMEOUT_EN)
// PORTS
//  clk           in   1  clock; all state on posedge
//  rst_b         in   1  asynchronous, active-high reset
//  req_valid     in   1  request present
//  req_ready     out  1  high only in IDLE
//  req_dividend  in   W  dividend, sampled on req_valid&&req_ready
//  req_divisor   in   W  divisor, sampled with dividend
//  beginSignal   out  1  start pulse to divider, exactly one cycle
//  inbus         out  W  operand bus to divider
//  outbus        in   W  result bus from divider
//  endSignal     in   1  divider done; outbus = quotient this cycle, remainder next cycle
//  rsp_valid     out  1  result available; held until rsp_ready
//  rsp_ready     in   1  consumer accepts
//  rsp_quotient  out  W  captured quotient
//  rsp_remainder out  W  captured remainder
//  rsp_error     out  1  timeout abort flag (constant 0 without macro)
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1, beginSignal=0, inbus=0, rsp_valid=0, rsp_*=0, rsp_error=0, cnt=0.
//  FSM (registered outputs): IDLE -> BEGIN -> LOAD_A -> WAIT -> CAP_R -> RESP -> IDLE.
//  IDLE: req_ready=1; on handshake latch operands, inbus<=dividend, beginSignal<=1 -> BEGIN.
//  BEGIN: beginSignal=1 for this one cycle, inbus=dividend; cnt<=1 -> LOAD_A.
//  LOAD_A: beginSignal=0, inbus=dividend until cnt==DVD_CYCLES-1, then inbus<=divisor -> WAIT.
//  WAIT: inbus=divisor; on endSignal=1 capture outbus into rsp_quotient -> CAP_R.
//  CAP_R: capture outbus into rsp_remainder, inbus<=0, rsp_valid<=1 -> RESP.
//  RESP: hold rsp_* stable; on rsp_valid&&rsp_ready drop rsp_valid -> IDLE (req_ready next cycle).
//  Latency: handshake to rsp_valid = DVD_CYCLES + divider cycles + 2.
//  endSignal outside WAIT ignored; begin never re-pulsed until RESP completes.
//  req_valid while busy: not accepted (req_ready=0), no loss of in-flight operands.
//  Divisor 0 passed through unchanged; result is whatever divider returns.
//  rst_b mid-operation: immediate return to reset values; divider must be reset with same rst_b.
//  No arithmetic in this block; values copied bit-exact, W bits, no extension.
// CONFIGURATION
//  SRT4_HOST_TIMEOUT_EN defined: cnt counts in WAIT; at TIMEOUT_CYCLES without endSignal go to
//   RESP with rsp_valid=1, rsp_error=1, rsp_quotient=rsp_remainder={W{1'b1}}, inbus<=0.
//   rsp_error cleared on next accepted request.
//  Undefined: WAIT indefinitely; rsp_error tied 0; no timeout counter logic synthesised.
// STRUCTURE
//  Shared include srt4_host_defs.v: state encodings (localparams ST_IDLE..ST_RESP, 3-bit),
//   default W/DVD_CYCLES/TIMEOUT_CYCLES constants.
//  Sub-module: reuse existing counter block for cnt (load-0 / increment), one instance.
//  FSM + operand/result registers stay in this module.
// TESTING (bench instantiates srt4_host_seq + srt4, common clk/rst_b)
//  101/5 -> rsp_quotient=20, rsp_remainder=1, beginSignal high exactly 1 cycle, inbus=101 for
//   DVD_CYCLES cycles then 5.
//  255/16 -> 15 r15; 7/9 -> 0 r7, back-to-back requests, each only after prior RESP handshake.
//  rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_* stable, req_ready=0 throughout.
//  rst_b pulsed during WAIT -> all outputs at reset values same cycle; next 101/5 gives 20 r1.
//  Spurious endSignal in IDLE -> no capture, rsp_valid stays 0.
//  With SRT4_HOST_TIMEOUT_EN, divider stub never raising endSignal -> after 64 WAIT cycles
//   rsp_valid=1, rsp_error=1, results=8'hFF; without macro rsp_valid stays 0.

Source files
------------

// File: rtl/srt4_host_seq_pkg.sv
// Shared definitions for the srt4 host-side sequencer.
//   - default operand width and sequencing constants
//   - FSM state encoding (3-bit)
//   - counter width helper
package srt4_host_seq_pkg;

   localparam int W_DEF              = 8;
   localparam int DVD_CYCLES_DEF     = 2;
   localparam int TIMEOUT_CYCLES_DEF = 64;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_BEGIN  = 3'd1,
      ST_LOAD_A = 3'd2,
      ST_WAIT   = 3'd3,
      ST_CAP_R  = 3'd4,
      ST_RESP   = 3'd5
   } state_t;

   // Bits needed to hold the larger of two terminal counts.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/srt4_host_seq_if.sv
// Request/response port bundle of the srt4 host sequencer.
//   req_valid/req_ready      request handshake, operands req_dividend/req_divisor
//   rsp_valid/rsp_ready      response handshake, results rsp_quotient/rsp_remainder
//   rsp_error                timeout abort flag
// Modports: master = system side issuing requests, slave = sequencer.
interface srt4_host_seq_if #(parameter int W = srt4_host_seq_pkg::W_DEF);

   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] req_dividend;
   logic [W-1:0] req_divisor;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_quotient;
   logic [W-1:0] rsp_remainder;
   logic         rsp_error;

   modport master (
      output req_valid, req_dividend, req_divisor, rsp_ready,
      input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_error
   );

   modport slave (
      input  req_valid, req_dividend, req_divisor, rsp_ready,
      output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_error
   );

endinterface

// File: rtl/srt4_host_seq_cnt.sv
// Load-zero / increment counter used by the host sequencer.
//   clk, rst_b  clock, asynchronous active-high reset
//   clr         load zero (wins over inc)
//   inc         increment by one
//   cnt         current count
module srt4_host_seq_cnt #(
   parameter int CW = 7
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt
);

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b)    cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc) cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/srt4_host_seq.sv
// Host-side initiator for the srt4 divider. Accepts a (dividend, divisor)
// request, pulses beginSignal, presents the dividend then the divisor on
// inbus, waits for endSignal, captures quotient (end cycle) and remainder
// (following cycle) from outbus, and returns them on a valid/ready port.
// Values are copied bit-exact; no arithmetic is done here.
//
// Ports:
//   clk, rst_b      clock, asynchronous active-high reset (share rst_b with srt4)
//   host            slave side of srt4_host_seq_if (req_*/rsp_*)
//   beginSignal     one-cycle start pulse to the divider
//   inbus           operand bus to the divider
//   outbus          result bus from the divider
//   endSignal       divider done strobe
//
// Build option: define SRT4_HOST_TIMEOUT_EN to abort a WAIT lasting
// TIMEOUT_CYCLES with rsp_error=1 and all-ones results. Without it the
// sequencer waits indefinitely and rsp_error is constant 0.
module srt4_host_seq
   import srt4_host_seq_pkg::*;
#(
   parameter int W              = W_DEF,
   parameter int DVD_CYCLES     = DVD_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         rst_b,
   srt4_host_seq_if.slave host,
   output logic         beginSignal,
   output logic [W-1:0] inbus,
   input  logic [W-1:0] outbus,
   input  logic         endSignal
);

   localparam int           CW       = cnt_width(DVD_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CW-1:0] DVD_LAST = CW'(DVD_CYCLES - 1);

   state_t       state, state_n;
   logic         req_ready_r, req_ready_n;
   logic         begin_r, begin_n;
   logic [W-1:0] inbus_r, inbus_n;
   logic [W-1:0] divisor_r, divisor_n;
   logic         rsp_valid_r, rsp_valid_n;
   logic [W-1:0] quot_r, quot_n;
   logic [W-1:0] rem_r, rem_n;
   logic         cnt_clr, cnt_inc;
   logic [CW-1:0] cnt;
`ifdef SRT4_HOST_TIMEOUT_EN
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic         err_r, err_n;
`endif

   srt4_host_seq_cnt #(.CW(CW)) u_cnt (
      .clk   (clk),
      .rst_b (rst_b),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .cnt   (cnt)
   );

   always_comb begin
      state_n     = state;
      req_ready_n = req_ready_r;
      begin_n     = 1'b0;
      inbus_n     = inbus_r;
      divisor_n   = divisor_r;
      rsp_valid_n = rsp_valid_r;
      quot_n      = quot_r;
      rem_n       = rem_r;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
`ifdef SRT4_HOST_TIMEOUT_EN
      err_n       = err_r;
`endif
      case (state)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            // req_ready is high throughout IDLE, so req_valid alone is the handshake.
            if (host.req_valid) begin
               inbus_n     = host.req_dividend;
               divisor_n   = host.req_divisor;
               begin_n     = 1'b1;
               req_ready_n = 1'b0;
`ifdef SRT4_HOST_TIMEOUT_EN
               err_n       = 1'b0;
`endif
               state_n     = ST_BEGIN;
            end
         end
         ST_BEGIN: begin
            // A single dividend cycle means the divisor follows the begin cycle directly.
            if (DVD_CYCLES <= 1) begin
               inbus_n = divisor_r;
               cnt_clr = 1'b1;
               state_n = ST_WAIT;
            end else begin
               cnt_inc = 1'b1;
               state_n = ST_LOAD_A;
            end
         end
         ST_LOAD_A: begin
            if (cnt >= DVD_LAST) begin
               inbus_n = divisor_r;
               cnt_clr = 1'b1;
               state_n = ST_WAIT;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_WAIT: begin
            if (endSignal) begin
               quot_n  = outbus;
               state_n = ST_CAP_R;
            end
`ifdef SRT4_HOST_TIMEOUT_EN
            else if (cnt == TO_LAST) begin
               quot_n      = '1;
               rem_n       = '1;
               err_n       = 1'b1;
               inbus_n     = '0;
               rsp_valid_n = 1'b1;
               state_n     = ST_RESP;
            end else begin
               cnt_inc = 1'b1;
            end
`endif
         end
         ST_CAP_R: begin
            rem_n       = outbus;
            inbus_n     = '0;
            rsp_valid_n = 1'b1;
            state_n     = ST_RESP;
         end
         ST_RESP: begin
            if (host.rsp_ready) begin
               rsp_valid_n = 1'b0;
               req_ready_n = 1'b1;
               state_n     = ST_IDLE;
            end
         end
         default: begin
            req_ready_n = 1'b1;
            rsp_valid_n = 1'b0;
            state_n     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state       <= ST_IDLE;
         req_ready_r <= 1'b1;
         begin_r     <= 1'b0;
         inbus_r     <= '0;
         rsp_valid_r <= 1'b0;
         quot_r      <= '0;
         rem_r       <= '0;
      end else begin
         state       <= state_n;
         req_ready_r <= req_ready_n;
         begin_r     <= begin_n;
         inbus_r     <= inbus_n;
         rsp_valid_r <= rsp_valid_n;
         quot_r      <= quot_n;
         rem_r       <= rem_n;
      end
   end

   // Latched divisor is internal and always reloaded before use.
   always_ff @(posedge clk) begin
      divisor_r <= divisor_n;
   end

`ifdef SRT4_HOST_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) err_r <= 1'b0;
      else       err_r <= err_n;
   end
   assign host.rsp_error = err_r;
`else
   assign host.rsp_error = 1'b0;
`endif

   assign host.req_ready     = req_ready_r;
   assign host.rsp_valid     = rsp_valid_r;
   assign host.rsp_quotient  = quot_r;
   assign host.rsp_remainder = rem_r;
   assign beginSignal        = begin_r;
   assign inbus              = inbus_r;

endmodule

// File: tb/tb_srt4_host_seq.sv
// Bench for srt4_host_seq with a behavioural srt4 divider stand-in,
// a request driver, a randomly stalling consumer and a scoreboard monitor.
module tb_srt4_host_seq;
   import srt4_host_seq_pkg::*;

   localparam int W   = 8;
   localparam int DVD = 2;
   localparam int TO  = 64;

   logic         clk = 1'b0;
   logic         rst_b;
   logic         beginSignal;
   logic [W-1:0] inbus;
   logic [W-1:0] outbus;
   logic         endSignal;

   srt4_host_seq_if #(.W(W)) bus ();

   srt4_host_seq #(.W(W), .DVD_CYCLES(DVD), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .host        (bus),
      .beginSignal (beginSignal),
      .inbus       (inbus),
      .outbus      (outbus),
      .endSignal   (endSignal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         err;
   } exp_t;

   exp_t sb[$];
   int   n_chk   = 0;
   int   n_fail  = 0;
   int   n_acc   = 0;
   int   n_begin = 0;
   bit   hold       = 0;
   bit   stub_dead  = 0;
   int   stub_lat   = 0;
   int   spur_cnt   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Divider behaviour: quotient/remainder; divide-by-zero yields all-ones, dividend.
   function automatic logic [W-1:0] div_q(input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == 0) ? {W{1'b1}} : a / b;
   endfunction
   function automatic logic [W-1:0] div_r(input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == 0) ? a : a % b;
   endfunction

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit dead);
      exp_t e;
      if (dead) begin
         e.q = {W{1'b1}}; e.r = {W{1'b1}}; e.err = 1'b1;
      end else begin
         e.q = div_q(a, b); e.r = div_r(a, b); e.err = 1'b0;
      end
      return e;
   endfunction

   // Divider stand-in: samples the dividend at the begin cycle, checks it is
   // held for DVD cycles, samples the divisor, then answers after a latency.
   initial begin : divider
      logic [W-1:0] dvd, dvs;
      bit           alive;
      int           lat;
      int           spur_seen;
      spur_seen = 0;
      endSignal = 1'b0;
      outbus    = '0;
      dvs       = '0;
      forever begin
         @(negedge clk);
         if (spur_cnt != spur_seen) begin
            spur_seen = spur_cnt;
            endSignal = 1'b1;
            outbus    = 8'hA5;
            @(negedge clk);
            endSignal = 1'b0;
            outbus    = '0;
         end else if (!rst_b && beginSignal) begin
            n_begin++;
            dvd   = inbus;
            alive = 1;
            for (int k = 1; k < DVD && alive; k++) begin
               @(negedge clk);
               if (rst_b) alive = 0;
               else begin
                  chk("begin_one_cycle", beginSignal, 0);
                  chk("inbus_dividend", inbus, dvd);
               end
            end
            if (alive) begin
               @(negedge clk);
               if (rst_b) alive = 0;
               else dvs = inbus;
            end
            if (alive && stub_dead) begin
               while (!rst_b && stub_dead) @(negedge clk);
               alive = 0;
            end
            if (alive) begin
               lat = (stub_lat > 0) ? stub_lat : $urandom_range(1, 8);
               for (int k = 0; k < lat && alive; k++) begin
                  @(negedge clk);
                  if (rst_b) alive = 0;
               end
            end
            if (alive) begin
               endSignal = 1'b1;
               outbus    = div_q(dvd, dvs);
               @(negedge clk);
               endSignal = 1'b0;
               outbus    = div_r(dvd, dvs);
               @(negedge clk);
               outbus    = W'($urandom);
            end
         end
      end
   end

   // Consumer: random back-pressure, or none accepted while hold is set.
   initial begin : consumer
      bus.rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.rsp_ready = !hold && ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: a response is consumed at the edge following a negedge with valid&&ready.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_b && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL rsp_unexpected: got q=%0d r=%0d required none", bus.rsp_quotient, bus.rsp_remainder);
            end else begin
               e = sb.pop_front();
               chk("rsp_quotient", bus.rsp_quotient, e.q);
               chk("rsp_remainder", bus.rsp_remainder, e.r);
               chk("rsp_error", bus.rsp_error, e.err);
            end
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit dead);
      int g;
      g = 0;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_dividend = a;
      bus.req_divisor  = b;
      while (!bus.req_ready && g < 500) begin
         @(negedge clk);
         g++;
      end
      chk("req_accept_bound", (g < 500), 1);
      if (g < 500) begin
         sb.push_back(model(a, b, dead));
         n_acc++;
         @(negedge clk);
      end
      bus.req_valid    = 1'b0;
      bus.req_dividend = W'($urandom);
      bus.req_divisor  = W'($urandom);
   endtask

   task automatic wait_drain(input string name);
      int g;
      g = 0;
      while ((sb.size() != 0 || !bus.req_ready || bus.rsp_valid) && g < 2000) begin
         @(negedge clk);
         g++;
      end
      chk(name, (g < 2000), 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req_ready"}, bus.req_ready, 1);
      chk({tag, "_begin"}, beginSignal, 0);
      chk({tag, "_inbus"}, inbus, 0);
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      chk({tag, "_rsp_q"}, bus.rsp_quotient, 0);
      chk({tag, "_rsp_r"}, bus.rsp_remainder, 0);
      chk({tag, "_rsp_err"}, bus.rsp_error, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst_b = 1'b1;
      #1 chk_reset("rst_mid");
      sb.delete();
      stub_dead = 0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_b = 1'b0;
      stub_lat = 0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      exp_t         e;
      logic [W-1:0] a, b;
      int           seen;
      rst_b            = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst_b = 1'b0;

      send(8'd101, 8'd5, 0);
      wait_drain("drain_101_5");

      send(8'd255, 8'd16, 0);
      send(8'd7, 8'd9, 0);
      wait_drain("drain_b2b");

      // Response stalled for 10 cycles.
      hold = 1;
      send(8'd255, 8'd16, 0);
      seen = 0;
      while (!bus.rsp_valid && seen < 200) begin
         @(negedge clk);
         seen++;
      end
      e = model(8'd255, 8'd16, 0);
      for (int i = 0; i < 10; i++) begin
         chk("hold_rsp_valid", bus.rsp_valid, 1);
         chk("hold_rsp_q", bus.rsp_quotient, e.q);
         chk("hold_rsp_r", bus.rsp_remainder, e.r);
         chk("hold_req_ready", bus.req_ready, 0);
         @(negedge clk);
      end
      hold = 0;
      wait_drain("drain_hold");

      // Reset while the host waits on the divider.
      stub_lat = 20;
      send(8'd101, 8'd5, 0);
      repeat (4) @(negedge clk);
      pulse_reset();
      send(8'd101, 8'd5, 0);
      wait_drain("drain_after_reset");

      // Spurious endSignal while idle.
      @(negedge clk);
      #2 spur_cnt++;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.rsp_valid) seen++;
      end
      chk("spurious_no_rsp", seen, 0);
      chk("spurious_req_ready", bus.req_ready, 1);

      for (int i = 0; i < 30; i++) begin
         a = W'($urandom);
         b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         send(a, b, 0);
      end
      wait_drain("drain_random");

      // Divider never finishes.
      stub_dead = 1;
`ifdef SRT4_HOST_TIMEOUT_EN
      send(8'd77, 8'd3, 1);
      wait_drain("drain_timeout");
      stub_dead = 0;
      send(8'd101, 8'd5, 0);
      wait_drain("drain_after_timeout");
`else
      send(8'd77, 8'd3, 0);
      seen = 0;
      repeat (TO + 20) begin
         @(negedge clk);
         if (bus.rsp_valid) seen++;
      end
      chk("no_timeout_rsp", seen, 0);
      pulse_reset();
      send(8'd101, 8'd5, 0);
      wait_drain("drain_after_stall");
`endif

      chk("begin_count", n_begin, n_acc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
